// File: rtl/ddr4_v2_2_20_cal_wr_sched_pkg.sv
// rtl/ddr4_v2_2_20_cal_wr_sched_pkg.sv - shared types and helpers for the write-CAS scheduler
package ddr4_v2_2_20_cal_wr_sched_pkg;

    // IDLE: cal port owns the scheduler. DRAIN: waiting for cal writes to retire.
    // MC: MC ports own the scheduler until reset.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        MC    = 2'd2
    } sched_state_e;

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT2 = 2'd2;

    // Width of the remaining-spacing counter, in tCK.
    localparam int GAP_W = 5;

    // Saturating subtract: never wraps below zero.
    function automatic logic [GAP_W-1:0] sat_sub(input logic [GAP_W-1:0] a,
                                                 input logic [GAP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/ddr4_v2_2_20_cal_wr_rr_arb.sv
// rtl/ddr4_v2_2_20_cal_wr_rr_arb.sv - round-robin arbiter over eligible MC write ports
// Ports:
//   req   in  NREQ  valid requests
//   mask  in  NREQ  per-port eligibility (rank spacing satisfied)
//   ptr   in  PW    highest-priority port index
//   grant out NREQ  one-hot grant, zero when nothing is both valid and eligible
module ddr4_v2_2_20_cal_wr_rr_arb
    import ddr4_v2_2_20_cal_wr_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;

    // Walk ports starting at ptr; the first valid and eligible one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx] && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr4_v2_2_20_cal_wr_cas_sched.sv
// rtl/ddr4_v2_2_20_cal_wr_cas_sched.sv - write-CAS scheduler for the cal/MC write path
// Ports:
//   clk, rst                     fabric clock (4 tCK/cycle), synchronous active-high reset
//   calDone                      selects the MC ports once calibration is complete
//   cal_valid/rank/buf, cal_ready cal write request and its accept
//   req_valid/rank/buf, req_ready MC write requests and one-hot accept
//   wr_done                      one pulse per retired write
//   wrCAS/casSlot/winBuf/winRank issued write, registered, one cycle after accept
//   outstanding                  writes issued and not yet retired
module ddr4_v2_2_20_cal_wr_cas_sched
    import ddr4_v2_2_20_cal_wr_sched_pkg::*;
#(
    parameter int DBAW     = 5,
    parameter int NREQ     = 2,
    parameter int TCCD     = 4,
    parameter int RANK_GAP = 2,
    parameter int MAX_OUT  = 8,
    parameter int SLOT2_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calDone,
    input  logic                 cal_valid,
    input  logic [1:0]           cal_rank,
    input  logic [DBAW-1:0]      cal_buf,
    output logic                 cal_ready,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_rank,
    input  logic [DBAW*NREQ-1:0] req_buf,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wr_done,
    output logic                 wrCAS,
    output logic [1:0]           casSlot,
    output logic [DBAW-1:0]      winBuf,
    output logic [1:0]           winRank,
    output logic [3:0]           outstanding
);

    localparam int              PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GAP_W-1:0] RG    = GAP_W'(RANK_GAP);
    localparam logic [GAP_W-1:0] TCCD_G = GAP_W'(TCCD);
    localparam logic [GAP_W-1:0] TCK_PER_CYC = GAP_W'(4);
    localparam logic [GAP_W:0]   TWO   = (GAP_W+1)'(2);
    localparam logic [3:0]       MAX_Q = 4'(MAX_OUT);

    sched_state_e     state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       last_rank_q, last_rank_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]       out_q, out_d;
    logic             wrcas_q, wrcas_d;
    logic [1:0]       slot_q, slot_d;
    logic [DBAW-1:0]  win_buf_q, win_buf_d;
    logic [1:0]       win_rank_q, win_rank_d;

    logic                 credit_ok;
    logic [2:0]           cal_pick;
    logic [NREQ-1:0]      req_elig;
    logic [NREQ-1:0][1:0] req_slot;
    logic [NREQ-1:0]      arb_req;
    logic [NREQ-1:0]      grant;
    logic [PW-1:0]        win_idx;
    logic                 cal_acc;
    logic                 acc;
    logic [1:0]           acc_rank;
    logic [1:0]           acc_slot;
    logic [DBAW-1:0]      acc_buf;
    logic [GAP_W-1:0]     acc_rg;

    // {eligible, slot} for a candidate rank. A rank change costs RANK_GAP extra tCK
    // on top of whatever spacing is still pending from the last CAS.
    function automatic logic [2:0] pick_slot(input logic [GAP_W-1:0] gap,
                                             input logic [1:0]       last,
                                             input logic [1:0]       rank);
        logic [GAP_W:0] eff;
        eff = {1'b0, gap} + ((rank != last) ? {1'b0, RG} : '0);
        if (eff == '0) begin
            return {1'b1, SLOT0};
        end else if ((SLOT2_EN != 0) && (eff <= TWO)) begin
            return {1'b1, SLOT2};
        end
        return {1'b0, SLOT0};
    endfunction

    always_comb begin
        req_elig = '0;
        req_slot = '0;
        for (int i = 0; i < NREQ; i++) begin
            {req_elig[i], req_slot[i]} = pick_slot(gap_q, last_rank_q, req_rank[2*i +: 2]);
        end
    end

    assign credit_ok = (out_q != MAX_Q);
    assign cal_pick  = pick_slot(gap_q, last_rank_q, cal_rank);
    assign cal_ready = (state_q == IDLE) && !calDone && credit_ok && cal_pick[2];
    assign arb_req   = ((state_q == MC) && credit_ok) ? req_valid : '0;

    ddr4_v2_2_20_cal_wr_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (arb_req),
        .mask  (req_elig),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign cal_acc  = cal_valid && cal_ready;
    assign acc      = cal_acc || (|grant);
    assign acc_rank = cal_acc ? cal_rank : req_rank[2*int'(win_idx) +: 2];
    assign acc_buf  = cal_acc ? cal_buf  : req_buf[DBAW*int'(win_idx) +: DBAW];
    assign acc_slot = cal_acc ? cal_pick[1:0] : req_slot[win_idx];
    assign acc_rg   = (acc_rank != last_rank_q) ? RG : '0;

    always_comb begin
        state_d     = state_q;
        gap_d       = sat_sub(gap_q, TCK_PER_CYC);
        last_rank_d = last_rank_q;
        rr_ptr_d    = rr_ptr_q;
        out_d       = out_q;
        wrcas_d     = 1'b0;
        slot_d      = slot_q;
        win_buf_d   = win_buf_q;
        win_rank_d  = win_rank_q;

        if (acc) begin
            wrcas_d     = 1'b1;
            slot_d      = acc_slot;
            win_buf_d   = acc_buf;
            win_rank_d  = acc_rank;
            last_rank_d = acc_rank;
            // Spacing left after this CAS, measured from the start of the next cycle.
            gap_d       = sat_sub(GAP_W'(acc_slot) + TCCD_G + acc_rg, TCK_PER_CYC);
            if (!cal_acc) begin
                rr_ptr_d = PW'((int'(win_idx) + 1) % NREQ);
            end
        end

        case ({acc, wr_done})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = (out_q != 4'd0) ? (out_q - 4'd1) : out_q;
            default: out_d = out_q;
        endcase

        case (state_q)
            IDLE:    if (calDone) state_d = (out_q == 4'd0) ? MC : DRAIN;
            DRAIN:   if (out_q == 4'd0) state_d = MC;
            MC:      state_d = MC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            last_rank_q <= '0;
            rr_ptr_q    <= '0;
            out_q       <= '0;
            wrcas_q     <= 1'b0;
            slot_q      <= '0;
            win_buf_q   <= '0;
            win_rank_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            last_rank_q <= last_rank_d;
            rr_ptr_q    <= rr_ptr_d;
            out_q       <= out_d;
            wrcas_q     <= wrcas_d;
            slot_q      <= slot_d;
            win_buf_q   <= win_buf_d;
            win_rank_q  <= win_rank_d;
        end
    end

    // A retirement with nothing in flight means the write datapath lost count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_done && (out_q == 4'd0)));
        end
    end

    assign wrCAS       = wrcas_q;
    assign casSlot     = slot_q;
    assign winBuf      = win_buf_q;
    assign winRank     = win_rank_q;
    assign outstanding = out_q;

endmodule

// File: tb/tb_ddr4_v2_2_20_cal_wr_cas_sched.sv
// tb/tb_ddr4_v2_2_20_cal_wr_cas_sched.sv - self-checking bench for the write-CAS scheduler
module tb_ddr4_v2_2_20_cal_wr_cas_sched;

    localparam int NREQ = 2;
    localparam int DBAW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        calDone;
    logic        cal_valid;
    logic [1:0]  cal_rank;
    logic [4:0]  cal_buf;
    logic        cal_ready;
    logic [1:0]  req_valid;
    logic [3:0]  req_rank;
    logic [9:0]  req_buf;
    logic [1:0]  req_ready;
    logic        wr_done;
    logic        wrCAS;
    logic [1:0]  casSlot;
    logic [4:0]  winBuf;
    logic [1:0]  winRank;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    ddr4_v2_2_20_cal_wr_cas_sched #(
        .DBAW     (DBAW),
        .NREQ     (NREQ),
        .TCCD     (4),
        .RANK_GAP (2),
        .MAX_OUT  (3),
        .SLOT2_EN (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .calDone     (calDone),
        .cal_valid   (cal_valid),
        .cal_rank    (cal_rank),
        .cal_buf     (cal_buf),
        .cal_ready   (cal_ready),
        .req_valid   (req_valid),
        .req_rank    (req_rank),
        .req_buf     (req_buf),
        .req_ready   (req_ready),
        .wr_done     (wr_done),
        .wrCAS       (wrCAS),
        .casSlot     (casSlot),
        .winBuf      (winBuf),
        .winRank     (winRank),
        .outstanding (outstanding)
    );

    typedef struct {
        logic       r;
        logic       cdn;
        logic       cv;
        logic [1:0] cr;
        logic [4:0] cb;
        logic [1:0] rv;
        logic [3:0] rr;
        logic [9:0] rb;
        logic       wd;
        logic       e_crdy;
        logic [1:0] e_rrdy;
        logic [1:0] e_slot;
        logic [3:0] e_out;
    } vec_t;

    typedef struct {
        logic [1:0] slot;
        logic [4:0] bidx;
        logic [1:0] rank;
    } iss_t;

    localparam int NV = 29;
    vec_t tbl [NV];
    iss_t sbq [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic cdn, input logic cv,
                                input logic [1:0] cr, input logic [4:0] cb,
                                input logic [1:0] rv, input logic [3:0] rr,
                                input logic [9:0] rb, input logic wd,
                                input logic crdy, input logic [1:0] rrdy,
                                input logic [1:0] slot, input logic [3:0] outv);
        vec_t v;
        v.r = r; v.cdn = cdn; v.cv = cv; v.cr = cr; v.cb = cb;
        v.rv = rv; v.rr = rr; v.rb = rb; v.wd = wd;
        v.e_crdy = crdy; v.e_rrdy = rrdy; v.e_slot = slot; v.e_out = outv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              r cdn cv cr    cb     rv     rr       rb              wd crdy rrdy   slot  out
        // cal back-to-back on rank 0, slot 0 every cycle, credits refilled by wr_done
        tbl[0]  = mk(0, 0, 1, 2'd0, 5'd1,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd1);
        tbl[1]  = mk(0, 0, 1, 2'd0, 5'd2,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd2);
        tbl[2]  = mk(0, 0, 1, 2'd0, 5'd3,  2'b00, 4'b0000, 10'd0,           1, 1, 2'b00, 2'd0, 4'd2);
        tbl[3]  = mk(0, 0, 1, 2'd0, 5'd4,  2'b00, 4'b0000, 10'd0,           1, 1, 2'b00, 2'd0, 4'd2);
        // rank switch 0->1: slot 2, then pending spacing stalls one cycle
        tbl[4]  = mk(0, 0, 1, 2'd1, 5'd5,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd2, 4'd3);
        tbl[5]  = mk(0, 0, 1, 2'd1, 5'd6,  2'b00, 4'b0000, 10'd0,           1, 0, 2'b00, 2'd0, 4'd2);
        tbl[6]  = mk(0, 0, 1, 2'd1, 5'd6,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd3);
        // credit cap: no accept while outstanding==3 until a wr_done retires one
        tbl[7]  = mk(0, 0, 1, 2'd1, 5'd7,  2'b00, 4'b0000, 10'd0,           0, 0, 2'b00, 2'd0, 4'd3);
        tbl[8]  = mk(0, 0, 1, 2'd1, 5'd7,  2'b00, 4'b0000, 10'd0,           0, 0, 2'b00, 2'd0, 4'd3);
        tbl[9]  = mk(0, 0, 1, 2'd1, 5'd7,  2'b00, 4'b0000, 10'd0,           1, 0, 2'b00, 2'd0, 4'd2);
        tbl[10] = mk(0, 0, 1, 2'd1, 5'd7,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd3);
        tbl[11] = mk(0, 0, 1, 2'd0, 5'd8,  2'b00, 4'b0000, 10'd0,           1, 0, 2'b00, 2'd0, 4'd2);
        tbl[12] = mk(0, 0, 1, 2'd0, 5'd8,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd2, 4'd3);
        // calDone rises with 3 in flight: drain, then MC ports round-robin 0,1,0
        tbl[13] = mk(0, 1, 1, 2'd0, 5'd9,  2'b11, 4'b0000, {5'd11, 5'd10}, 0, 0, 2'b00, 2'd0, 4'd3);
        tbl[14] = mk(0, 1, 1, 2'd0, 5'd9,  2'b11, 4'b0000, {5'd11, 5'd10}, 1, 0, 2'b00, 2'd0, 4'd2);
        tbl[15] = mk(0, 1, 1, 2'd0, 5'd9,  2'b11, 4'b0000, {5'd11, 5'd10}, 1, 0, 2'b00, 2'd0, 4'd1);
        tbl[16] = mk(0, 1, 1, 2'd0, 5'd9,  2'b11, 4'b0000, {5'd11, 5'd10}, 1, 0, 2'b00, 2'd0, 4'd0);
        tbl[17] = mk(0, 1, 1, 2'd0, 5'd9,  2'b11, 4'b0000, {5'd11, 5'd10}, 0, 0, 2'b00, 2'd0, 4'd0);
        tbl[18] = mk(0, 1, 0, 2'd0, 5'd0,  2'b11, 4'b0000, {5'd11, 5'd10}, 0, 0, 2'b01, 2'd0, 4'd1);
        tbl[19] = mk(0, 1, 0, 2'd0, 5'd0,  2'b11, 4'b0000, {5'd11, 5'd10}, 0, 0, 2'b10, 2'd0, 4'd2);
        tbl[20] = mk(0, 1, 0, 2'd0, 5'd0,  2'b11, 4'b0000, {5'd11, 5'd10}, 1, 0, 2'b01, 2'd0, 4'd2);
        // MC rank switches: slot 2, spacing stall, pointer order after the stall
        tbl[21] = mk(0, 1, 0, 2'd0, 5'd0,  2'b01, 4'b0001, {5'd13, 5'd12}, 1, 0, 2'b01, 2'd2, 4'd2);
        tbl[22] = mk(0, 1, 0, 2'd0, 5'd0,  2'b11, 4'b0001, {5'd13, 5'd12}, 1, 0, 2'b00, 2'd0, 4'd1);
        tbl[23] = mk(0, 1, 0, 2'd0, 5'd0,  2'b11, 4'b0001, {5'd15, 5'd14}, 0, 0, 2'b10, 2'd2, 4'd2);
        // calDone falls after MC: cal port stays shut, MC keeps going
        tbl[24] = mk(0, 0, 1, 2'd0, 5'd0,  2'b00, 4'b0000, 10'd0,           1, 0, 2'b00, 2'd0, 4'd1);
        tbl[25] = mk(0, 0, 1, 2'd0, 5'd18, 2'b01, 4'b0000, {5'd0, 5'd19},  0, 0, 2'b01, 2'd0, 4'd2);
        // reset mid-burst, then back to cal port at slot 0
        tbl[26] = mk(1, 0, 0, 2'd0, 5'd0,  2'b00, 4'b0000, 10'd0,           0, 0, 2'b00, 2'd0, 4'd0);
        tbl[27] = mk(0, 0, 1, 2'd0, 5'd20, 2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd1);
        tbl[28] = mk(0, 0, 0, 2'd0, 5'd0,  2'b00, 4'b0000, 10'd0,           0, 1, 2'b00, 2'd0, 4'd1);

        rst = 1'b1; calDone = 1'b0; cal_valid = 1'b0; cal_rank = '0; cal_buf = '0;
        req_valid = '0; req_rank = '0; req_buf = '0; wr_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wrCAS", 16'(wrCAS), 16'd0);
        chk("reset_casSlot", 16'(casSlot), 16'd0);
        chk("reset_winBuf", 16'(winBuf), 16'd0);
        chk("reset_winRank", 16'(winRank), 16'd0);
        chk("reset_outstanding", 16'(outstanding), 16'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = tbl[i].r;
            calDone   = tbl[i].cdn;
            cal_valid = tbl[i].cv;
            cal_rank  = tbl[i].cr;
            cal_buf   = tbl[i].cb;
            req_valid = tbl[i].rv;
            req_rank  = tbl[i].rr;
            req_buf   = tbl[i].rb;
            wr_done   = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_cal_ready", i), 16'(cal_ready), 16'(tbl[i].e_crdy));
            chk($sformatf("v%0d_req_ready", i), 16'(req_ready), 16'(tbl[i].e_rrdy));
            if (tbl[i].cv && tbl[i].e_crdy) begin
                iss_t e;
                e.slot = tbl[i].e_slot; e.bidx = tbl[i].cb; e.rank = tbl[i].cr;
                sbq.push_back(e);
            end else if (tbl[i].e_rrdy != 2'b00) begin
                iss_t e;
                int   w;
                w = tbl[i].e_rrdy[1] ? 1 : 0;
                e.slot = tbl[i].e_slot;
                e.bidx = tbl[i].rb[w*5 +: 5];
                e.rank = tbl[i].rr[w*2 +: 2];
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                iss_t e;
                e = sbq.pop_front();
                chk($sformatf("v%0d_wrCAS", i), 16'(wrCAS), 16'd1);
                chk($sformatf("v%0d_casSlot", i), 16'(casSlot), 16'(e.slot));
                chk($sformatf("v%0d_winBuf", i), 16'(winBuf), 16'(e.bidx));
                chk($sformatf("v%0d_winRank", i), 16'(winRank), 16'(e.rank));
            end else begin
                chk($sformatf("v%0d_wrCAS_idle", i), 16'(wrCAS), 16'd0);
            end
            if (tbl[i].r) begin
                chk($sformatf("v%0d_rst_casSlot", i), 16'(casSlot), 16'd0);
                chk($sformatf("v%0d_rst_winBuf", i), 16'(winBuf), 16'd0);
                chk($sformatf("v%0d_rst_winRank", i), 16'(winRank), 16'd0);
            end
            chk($sformatf("v%0d_outstanding", i), 16'(outstanding), 16'(tbl[i].e_out));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
